// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES-128 key-schedule constants, types and S-box helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int         AES_NR     = 10;
  localparam logic [7:0] AES_RCON_0 = 8'h01;

  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Entry 0 sits in the most significant byte of the table.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ks.sv
// ============================================================================
// Module  : ks
// Brief   : One combinational AES-128 key-schedule step plus next-rcon.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ks
  import aes_pkg::*;
(
  input  rkey_t       key_i,
  input  logic [7:0]  rcon_i,
  output rkey_t       key_o,
  output logic [7:0]  key_rcon_o
);

  logic [31:0] t, n0, n1, n2, n3;

  // Byte 0 lives in [7:0], so RotWord moves the low byte of w3 to the top.
  always_comb begin
    t  = sub_word({key_i[103:96], key_i[127:104]}) ^ {24'h0, rcon_i};
    n0 = key_i[31:0]   ^ t;
    n1 = key_i[63:32]  ^ n0;
    n2 = key_i[95:64]  ^ n1;
    n3 = key_i[127:96] ^ n2;
  end

  assign key_o      = {n3, n2, n1, n0};
  assign key_rcon_o = {rcon_i[6:0], 1'b0} ^ (rcon_i[7] ? 8'h1b : 8'h00);

endmodule

`default_nettype wire

// File: rtl/aes_key_expand.sv
// ============================================================================
// Module  : aes_key_expand
// Brief   : Iterative AES-128 key expansion into an indexed round-key store.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_key_expand
  import aes_pkg::*;
#(
  parameter int         NR     = AES_NR,
  parameter logic [7:0] RCON_0 = AES_RCON_0
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         key_v_i,
  input  logic [127:0] key_i,
  output logic         key_ready_o,
  output logic         done_o,
  input  logic         rd_v_i,
  input  logic [3:0]   rd_idx_i,
  output logic         rk_v_o,
  output logic         rk_err_o,
  output logic [127:0] rk_o
);

  localparam logic [3:0] LAST = 4'(NR);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rcon_q, rcon_d;
  rkey_t      prev_q, prev_d;
  logic       wr_last_q, wr_last_d;
  logic       done_q;
  logic       rk_v_q, rk_err_q;
  rkey_t      rk_q, rk_d;
  rkey_t      store_q [NR+1];

  rkey_t      ks_key;
  logic [7:0] ks_rcon;
  logic       load;
  logic       rd_ok;

  ks u_ks (
    .key_i      (prev_q),
    .rcon_i     (rcon_q),
    .key_o      (ks_key),
    .key_rcon_o (ks_rcon)
  );

  assign key_ready_o = (state_q != EXPAND);
  assign load        = key_v_i && key_ready_o;
  // Validity uses the pre-edge count, so a slot written this cycle is not yet readable.
  assign rd_ok       = rd_v_i && (rd_idx_i < cnt_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcon_d    = rcon_q;
    prev_d    = prev_q;
    wr_last_d = 1'b0;
    rk_d      = rk_q;
    if (load) begin
      state_d = EXPAND;
      cnt_d   = 4'd1;
      rcon_d  = RCON_0;
      prev_d  = key_i;
    end else if (state_q == EXPAND) begin
      prev_d = ks_key;
      rcon_d = ks_rcon;
      cnt_d  = cnt_q + 4'd1;
      if (cnt_q == LAST) begin
        state_d   = DONE;
        wr_last_d = 1'b1;
      end
    end
    if (rd_ok) begin
      rk_d = store_q[rd_idx_i];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rcon_q    <= RCON_0;
      prev_q    <= '0;
      wr_last_q <= 1'b0;
      done_q    <= 1'b0;
      rk_v_q    <= 1'b0;
      rk_err_q  <= 1'b0;
      rk_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcon_q    <= rcon_d;
      prev_q    <= prev_d;
      wr_last_q <= wr_last_d;
      done_q    <= wr_last_q;
      rk_v_q    <= rd_ok;
      rk_err_q  <= rd_v_i && !rd_ok;
      rk_q      <= rk_d;
    end
  end

  // Store contents carry no reset; cnt alone says which slots are meaningful.
  always_ff @(posedge clk) begin
    if (load) begin
      store_q[0] <= key_i;
    end else if (state_q == EXPAND) begin
      store_q[cnt_q] <= ks_key;
    end
  end

  assign done_o   = done_q;
  assign rk_v_o   = rk_v_q;
  assign rk_err_o = rk_err_q;
  assign rk_o     = rk_q;

endmodule

`default_nettype wire
